// File: rtl/phase_sweep_gen_if.sv
// Output beat bus of phase_sweep_gen: valid/ready handshake carrying phase word,
// function select and running sample index.
interface phase_sweep_gen_if #(
  parameter int PHASE_W = 16,
  parameter int SEL_W   = 7,
  parameter int CNT_W   = 32
) ();
  logic               out_valid;
  logic               out_ready;
  logic [PHASE_W-1:0] phase;
  logic [SEL_W-1:0]   func_sel;
  logic [CNT_W-1:0]   sample_idx;

  modport master (output out_valid, phase, func_sel, sample_idx, input out_ready);
  modport slave  (input out_valid, phase, func_sel, sample_idx, output out_ready);
endinterface

// File: rtl/phase_sweep_gen.sv
// Bounded, restartable phase sweep source for the sin/cos evaluator: emits
// num_samples phase words spaced by step, with SIN/COS select and sample index.
module phase_sweep_gen #(
  parameter int PHASE_W = 16,
  parameter int SEL_W   = 7,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [PHASE_W-1:0] step_i,
  input  logic [CNT_W-1:0]   num_samples_i,
  input  logic [1:0]         mode_i,
  output logic               busy_o,
  output logic               done_o,
  phase_sweep_gen_if.master  out_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] MODE_SIN = 2'b01;
  localparam logic [1:0] MODE_COS = 2'b10;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [1:0]         mode_q, mode_d;
  logic               sin_q, sin_d;
  logic               stop_pend_q, stop_pend_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               handshake_s;
  logic               last_s;
  logic               alt_s;

  assign handshake_s = valid_q && out_if.out_ready;
  assign last_s      = (idx_q == (count_q - CNT_W'(1)));
  // mode 11 behaves like 00 (alternate SIN/COS)
  assign alt_s       = (mode_q != MODE_SIN) && (mode_q != MODE_COS);

  // Next-state and datapath update for the sweep FSM
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    phase_d     = phase_q;
    count_d     = count_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    sin_d       = sin_q;
    stop_pend_d = stop_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          step_d  = step_i;
          count_d = num_samples_i;
          mode_d  = mode_i;
          phase_d = {PHASE_W{1'b0}};
          idx_d   = {CNT_W{1'b0}};
          sin_d   = (mode_i != MODE_COS);
          if (num_samples_i == {CNT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (handshake_s) begin
          if (last_s || stop_pend_q || stop_i) begin
            state_d = ST_DONE;
          end else begin
            phase_d = phase_q + step_q;
            idx_d   = idx_q + CNT_W'(1);
            sin_d   = alt_s ? ~sin_q : sin_q;
          end
        end else if (stop_i) begin
          // the offered beat is never withdrawn; the sweep ends once it is taken
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
      end
      ST_DONE: begin
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= {PHASE_W{1'b0}};
      phase_q     <= {PHASE_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      idx_q       <= {CNT_W{1'b0}};
      mode_q      <= 2'b00;
      sin_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      sin_q       <= sin_d;
      stop_pend_q <= stop_pend_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_if.out_valid  = valid_q;
  assign out_if.phase      = phase_q;
  assign out_if.func_sel   = {{(SEL_W-1){1'b0}}, sin_q};
  assign out_if.sample_idx = idx_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;

endmodule

// File: tb/tb_phase_sweep_gen.sv
// Self-checking bench for phase_sweep_gen: directed vector table, hand-written
// backpressure/stop/reset sequences, and randomized sweeps against a beat model.
module tb_phase_sweep_gen;
  localparam int PHASE_W = 16;
  localparam int SEL_W   = 7;
  localparam int CNT_W   = 32;
  localparam int BUDGET  = 2000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] step;
  logic [CNT_W-1:0]   num;
  logic [1:0]         mode;
  logic               busy;
  logic               done;
  int                 checks   = 0;
  int                 failures = 0;

  phase_sweep_gen_if #(.PHASE_W(PHASE_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  phase_sweep_gen #(.PHASE_W(PHASE_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .stop_i        (stop),
    .step_i        (step),
    .num_samples_i (num),
    .mode_i        (mode),
    .busy_o        (busy),
    .done_o        (done),
    .out_if        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] step;
    int          n;
    int          stop_at;
    int          ready_pct;
    int          exp_beats;
    int          exp_cycles;
    logic [15:0] exp_last_phase;
    logic [31:0] exp_last_idx;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a sweep sits at k*step modulo the phase full scale
  function automatic logic [15:0] exp_phase(input logic [15:0] st, input int k);
    logic [63:0] p;
    p = 64'(st) * 64'(k);
    return p[15:0];
  endfunction

  function automatic logic [6:0] exp_sel(input logic [1:0] m, input int k);
    if (m == 2'b01) return 7'b0000001;
    if (m == 2'b10) return 7'b0000000;
    return (k % 2 == 0) ? 7'b0000001 : 7'b0000000;
  endfunction

  task automatic run_sweep(input logic [1:0] m, input logic [15:0] st, input int n,
                           input int stop_at, input int ready_pct,
                           output int beats, output int cycles,
                           output logic [15:0] last_phase, output logic [31:0] last_idx);
    int   exp_beats;
    logic hs;
    bit   stop_sent;
    exp_beats = (stop_at >= 0 && stop_at < n) ? stop_at + 1 : n;
    beats     = 0;
    cycles    = 0;
    stop_sent = 1'b0;
    start = 1'b1; mode = m; step = st; num = 32'(n);
    tick();
    start = 1'b0;
    mode  = 2'($urandom);
    step  = 16'($urandom);
    num   = 32'($urandom_range(1, 50));
    chk("first_valid", bus.out_valid, n > 0);
    while (cycles < BUDGET && !done) begin
      stop = 1'b0;
      if (bus.out_valid) begin
        chk("phase", bus.phase, exp_phase(st, beats));
        chk("func_sel", bus.func_sel, exp_sel(m, beats));
        chk("sample_idx", bus.sample_idx, beats);
        if (!stop_sent && stop_at >= 0 && beats == stop_at) begin
          stop      = 1'b1;
          stop_sent = 1'b1;
        end
      end
      chk("busy", busy, bus.out_valid);
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
      hs = bus.out_valid && bus.out_ready;
      tick();
      cycles++;
      if (hs) beats++;
    end
    stop          = 1'b0;
    bus.out_ready = 1'b0;
    chk("done_timeout", cycles < BUDGET, 1);
    chk("beat_count", beats, exp_beats);
    chk("done_valid_low", bus.out_valid, 0);
    tick();
    chk("done_pulse_width", done, 0);
    chk("busy_after", busy, 0);
    last_phase = bus.phase;
    last_idx   = bus.sample_idx;
  endtask

  initial begin
    vec_t        vecs[6];
    int          beats;
    int          cycles;
    logic [15:0] lp;
    logic [31:0] li;

    vecs[0] = '{2'b00, 16'h02FF,   4, -1, 100, 4,  4, 16'h08FD, 32'd3};
    vecs[1] = '{2'b01, 16'hC000,   4, -1, 100, 4,  4, 16'h4000, 32'd3};
    vecs[2] = '{2'b10, 16'h0001,   2, -1, 100, 2,  2, 16'h0001, 32'd1};
    vecs[3] = '{2'b00, 16'h1234,   0, -1, 100, 0,  0, 16'h0000, 32'd0};
    vecs[4] = '{2'b00, 16'h0100, 100,  2,  30, 3, -1, 16'h0200, 32'd2};
    vecs[5] = '{2'b11, 16'hFFFF,   3, -1,  50, 3, -1, 16'hFFFE, 32'd2};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = 16'h0; num = 32'h0; mode = 2'b00;
    bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_phase", bus.phase, 0);
    chk("rst_sel", bus.func_sel, 0);
    chk("rst_idx", bus.sample_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i].mode, vecs[i].step, vecs[i].n, vecs[i].stop_at, vecs[i].ready_pct,
                beats, cycles, lp, li);
      chk("vec_beats", beats, vecs[i].exp_beats);
      if (vecs[i].exp_cycles >= 0) chk("vec_cycles", cycles, vecs[i].exp_cycles);
      chk("vec_last_phase", lp, vecs[i].exp_last_phase);
      chk("vec_last_idx", li, vecs[i].exp_last_idx);
    end

    // Backpressure on beat 1 for three cycles
    start = 1'b1; mode = 2'b00; step = 16'h02FF; num = 32'd4; bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_b0_phase", bus.phase, 16'h0000);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_phase", bus.phase, 16'h02FF);
      chk("bp_hold_sel", bus.func_sel, 7'b0000000);
      chk("bp_hold_idx", bus.sample_idx, 1);
      tick();
    end
    bus.out_ready = 1'b1;
    chk("bp_b1_idx", bus.sample_idx, 1);
    tick();
    chk("bp_b2_phase", bus.phase, 16'h05FE);
    chk("bp_b2_sel", bus.func_sel, 7'b0000001);
    tick();
    chk("bp_b3_phase", bus.phase, 16'h08FD);
    chk("bp_b3_idx", bus.sample_idx, 3);
    tick();
    chk("bp_done", done, 1);
    chk("bp_valid_low", bus.out_valid, 0);
    tick();
    chk("bp_done_clear", done, 0);
    bus.out_ready = 1'b0;

    // Stop raised while beat 2 is backpressured
    start = 1'b1; mode = 2'b00; step = 16'h0100; num = 32'd100; bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("stop_idx2", bus.sample_idx, 2);
    bus.out_ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("stop_hold_valid", bus.out_valid, 1);
      chk("stop_hold_idx", bus.sample_idx, 2);
      chk("stop_hold_phase", bus.phase, 16'h0200);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("stop_valid_low", bus.out_valid, 0);
    chk("stop_done", done, 1);
    chk("stop_final_idx", bus.sample_idx, 2);
    tick();
    chk("stop_done_clear", done, 0);
    chk("stop_busy", busy, 0);

    // Reset mid-run, then a fresh sweep that ignores a second start
    start = 1'b1; mode = 2'b01; step = 16'h0010; num = 32'd20; bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_idx5", bus.sample_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_phase", bus.phase, 0);
    chk("arst_idx", bus.sample_idx, 0);
    chk("arst_sel", bus.func_sel, 0);
    chk("arst_busy", busy, 0);
    tick();
    chk("arst_no_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", bus.out_valid, 0);
    start = 1'b1; mode = 2'b01; step = 16'h0010; num = 32'd5;
    tick();
    start = 1'b0;
    chk("fresh_phase", bus.phase, 16'h0000);
    chk("fresh_idx", bus.sample_idx, 0);
    tick(); tick();
    start = 1'b1; mode = 2'b10; step = 16'h1000; num = 32'd2;
    tick();
    start = 1'b0;
    chk("rerun_phase", bus.phase, 16'h0030);
    chk("rerun_idx", bus.sample_idx, 3);
    chk("rerun_sel", bus.func_sel, 7'b0000001);
    tick();
    chk("rerun_phase4", bus.phase, 16'h0040);
    tick();
    chk("rerun_done", done, 1);
    tick();
    bus.out_ready = 1'b0;

    // Randomized sweeps against the beat model
    for (int r = 0; r < 25; r++) begin
      logic [1:0]  m;
      logic [15:0] st;
      int          n;
      int          sa;
      int          pct;
      m   = 2'($urandom);
      st  = 16'($urandom);
      n   = $urandom_range(0, 12);
      sa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1;
      pct = $urandom_range(30, 100);
      run_sweep(m, st, n, sa, pct, beats, cycles, lp, li);
      chk("rnd_last_phase", lp, (beats > 0) ? exp_phase(st, beats - 1) : 16'h0000);
      chk("rnd_last_idx", li, (beats > 0) ? 32'(beats - 1) : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
